// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of the single-port SDRAM controller: registers the
// winning request, holds it toward the controller, and returns data plus a ready pulse.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk_48mhz,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic [31:0]       m0_rdata,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic [31:0]       m1_rdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic              ctl_req,
  output logic              ctl_we,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [31:0]       ctl_wdata,
  output logic [3:0]        ctl_wmask,
  input  logic [31:0]       ctl_rdata,
  input  logic              ctl_ready,
  output logic              grant
);

  localparam int TMO_W  = (TIMEOUT  < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wmask;
  } mreq_t;

  state_t              state, state_nxt;
  logic                last_grant;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                take, win, finish, tmo_hit;
  mreq_t               req0, req1, sel;
  logic [31:0]         rd_nxt;

  assign req0    = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, wmask: m0_wmask};
  assign req1    = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, wmask: m1_wmask};
  assign sel     = win ? req1 : req0;
  assign rd_nxt  = tmo_hit ? 32'hDEADBEEF : ctl_rdata;
  // Decoded from state so that an async reset drops the controller request at once.
  assign ctl_req = (state == ISSUE);

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    win       = 1'b0;
    finish    = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ISSUE;
          if (m0_req && m1_req)
            win = (FIXED_PRIO != 0) ? (wait_cnt == WAIT_W'(MAX_WAIT)) : ~last_grant;
          else
            win = m1_req;
        end
      end
      ISSUE: begin
        if (ctl_ready) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      ctl_we     <= 1'b0;
      ctl_addr   <= '0;
      ctl_wdata  <= '0;
      ctl_wmask  <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      if (take) begin
        ctl_we     <= sel.we;
        ctl_addr   <= sel.addr;
        ctl_wdata  <= sel.wdata;
        ctl_wmask  <= sel.wmask;
        grant      <= win;
        last_grant <= win;
        tmo_cnt    <= '0;
        // Starvation guard only counts two-way losses by master 1.
        if (FIXED_PRIO != 0) begin
          if (win)
            wait_cnt <= '0;
          else if (m1_req && wait_cnt != WAIT_W'(MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;
        end
      end
      if (state == ISSUE && !finish)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (finish) begin
        if (grant) begin
          m1_rdata <= rd_nxt;
          m1_ready <= 1'b1;
          m1_err   <= tmo_hit;
        end else begin
          m0_rdata <= rd_nxt;
          m0_ready <= 1'b1;
          m0_err   <= tmo_hit;
        end
      end
    end
  end

endmodule
